// File: rtl/hwpf_prefetch_responder.sv
// Target end of the HW-prefetcher dcache channel: queues CMO prefetches, filters duplicates/illegal ops,
// forwards to the miss engine and returns one response per request. Filter enabled by HWPF_PREFETCH_RSP_FILTER_EN.
module hwpf_prefetch_responder #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned FILTER_ENTRIES = 8,
  parameter int unsigned NLINE_W        = 26,
  parameter int unsigned TID_W          = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NLINE_W-1:0] req_nline_i,
  input  logic [3:0]         req_op_i,
  input  logic [2:0]         req_size_i,
  input  logic [TID_W-1:0]   req_tid_i,
  input  logic               req_need_rsp_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [NLINE_W-1:0] mem_req_nline_o,
  output logic               rsp_valid_o,
  output logic [TID_W-1:0]   rsp_tid_o,
  output logic               rsp_error_o,
  input  logic               filter_clear_i,
  output logic               busy_o
);

  localparam int unsigned PTR_W        = $clog2(DEPTH);
  localparam logic [3:0]  OP_CMO       = 4'h2;
  localparam logic [2:0]  CMO_PREFETCH = 3'h1;

  function automatic logic is_legal(input logic [3:0] op, input logic [2:0] size);
    return (op == OP_CMO) && (size == CMO_PREFETCH);
  endfunction

  logic [NLINE_W-1:0] fifo_nline [DEPTH];
  logic [TID_W-1:0]   fifo_tid   [DEPTH];
  logic               fifo_need  [DEPTH];
  logic               fifo_err   [DEPTH];
  logic [PTR_W:0]     wptr_p0, rptr_p0;

  logic               full, empty, push, pop;
  logic               head_vld, head_illegal, head_hit, head_fwd, fwd_fire;
  logic [NLINE_W-1:0] head_nline;
  logic               filter_hit;

  logic               rsp_vld_p1;
  logic [TID_W-1:0]   rsp_tid_p1;
  logic               rsp_err_p1;

  // Stage p0: request FIFO and head-entry decision
  assign empty = (wptr_p0 == rptr_p0);
  assign full  = (wptr_p0[PTR_W] != rptr_p0[PTR_W]) &&
                 (wptr_p0[PTR_W-1:0] == rptr_p0[PTR_W-1:0]);
  assign push  = req_valid_i && !full;

  assign head_vld     = !empty;
  assign head_nline   = fifo_nline[rptr_p0[PTR_W-1:0]];
  assign head_illegal = head_vld && fifo_err[rptr_p0[PTR_W-1:0]];
  assign head_hit     = head_vld && !head_illegal && filter_hit;
  assign head_fwd     = head_vld && !head_illegal && !filter_hit;
  assign fwd_fire     = head_fwd && mem_req_ready_i;
  assign pop          = head_illegal || head_hit || fwd_fire;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_nline[wptr_p0[PTR_W-1:0]] <= req_nline_i;
      fifo_tid[wptr_p0[PTR_W-1:0]]   <= req_tid_i;
      fifo_need[wptr_p0[PTR_W-1:0]]  <= req_need_rsp_i;
      fifo_err[wptr_p0[PTR_W-1:0]]   <= !is_legal(req_op_i, req_size_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else begin
      if (push) wptr_p0 <= wptr_p0 + 1'b1;
      if (pop)  rptr_p0 <= rptr_p0 + 1'b1;
    end
  end

`ifdef HWPF_PREFETCH_RSP_FILTER_EN
  localparam int unsigned RR_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;

  logic [NLINE_W-1:0]        flt_nline [FILTER_ENTRIES];
  logic [FILTER_ENTRIES-1:0] flt_vld;
  logic [RR_W-1:0]           flt_rr;

  always_comb begin
    filter_hit = 1'b0;
    for (int i = 0; i < FILTER_ENTRIES; i++) begin
      if (flt_vld[i] && (flt_nline[i] == head_nline)) filter_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fwd_fire) flt_nline[flt_rr] <= head_nline;
  end

  // A clear in the same cycle as an insert also drops the new entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flt_vld <= '0;
      flt_rr  <= '0;
    end else begin
      if (filter_clear_i)  flt_vld         <= '0;
      else if (fwd_fire)   flt_vld[flt_rr] <= 1'b1;
      if (fwd_fire) begin
        flt_rr <= (flt_rr == RR_W'(FILTER_ENTRIES - 1)) ? '0 : flt_rr + 1'b1;
      end
    end
  end
`else
  logic unused_filter_clear;
  assign filter_hit          = 1'b0;
  assign unused_filter_clear = filter_clear_i ^ (FILTER_ENTRIES == 0);
`endif

  // Stage p1: registered response, one cycle after the pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_p1 <= 1'b0;
      rsp_tid_p1 <= '0;
      rsp_err_p1 <= 1'b0;
    end else begin
      rsp_vld_p1 <= pop && fifo_need[rptr_p0[PTR_W-1:0]];
      rsp_tid_p1 <= (pop && fifo_need[rptr_p0[PTR_W-1:0]]) ? fifo_tid[rptr_p0[PTR_W-1:0]] : '0;
      rsp_err_p1 <= pop && fifo_need[rptr_p0[PTR_W-1:0]] && head_illegal;
    end
  end

  assign req_ready_o     = !full;
  assign mem_req_valid_o = head_fwd;
  assign mem_req_nline_o = head_fwd ? head_nline : '0;
  assign rsp_valid_o     = rsp_vld_p1;
  assign rsp_tid_o       = rsp_tid_p1;
  assign rsp_error_o     = rsp_err_p1;
  assign busy_o          = !empty || rsp_vld_p1;

endmodule

// File: tb/tb_hwpf_prefetch_responder.sv
// Directed bench for hwpf_prefetch_responder; expectations follow HWPF_PREFETCH_RSP_FILTER_EN.
module tb_hwpf_prefetch_responder;

`ifdef HWPF_PREFETCH_RSP_FILTER_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif
  localparam logic [3:0] OP_CMO  = 4'h2;
  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [2:0] SZ_PREF = 3'h1;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_need_rsp_i;
  logic [25:0] req_nline_i;
  logic [3:0]  req_op_i;
  logic [2:0]  req_size_i;
  logic [5:0]  req_tid_i;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [25:0] mem_req_nline_o;
  logic        rsp_valid_o, rsp_error_o, filter_clear_i, busy_o;
  logic [5:0]  rsp_tid_o;

  int checks = 0;
  int errors = 0;

  logic [25:0] fire_q[$];
  logic [5:0]  rtid_q[$];
  logic        rerr_q[$];

  always #5 clk = ~clk;

  hwpf_prefetch_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_nline_i(req_nline_i),
    .req_op_i(req_op_i), .req_size_i(req_size_i), .req_tid_i(req_tid_i),
    .req_need_rsp_i(req_need_rsp_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_nline_o(mem_req_nline_o),
    .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_error_o(rsp_error_o),
    .filter_clear_i(filter_clear_i), .busy_o(busy_o)
  );

  always @(negedge clk) begin
    if (rst_ni) begin
      if (mem_req_valid_o && mem_req_ready_i) fire_q.push_back(mem_req_nline_o);
      if (rsp_valid_o) begin
        rtid_q.push_back(rsp_tid_o);
        rerr_q.push_back(rsp_error_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    fire_q.delete(); rtid_q.delete(); rerr_q.delete();
  endtask

  task automatic send(input logic [25:0] nl, input logic [5:0] tid, input logic [3:0] op,
                      input logic [2:0] sz, input logic need);
    req_valid_i = 1'b1; req_nline_i = nl; req_tid_i = tid;
    req_op_i = op; req_size_i = sz; req_need_rsp_i = need;
    tick(1);
    req_valid_i = 1'b0; req_op_i = OP_CMO; req_size_i = SZ_PREF; req_need_rsp_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_nline_i = '0; req_op_i = OP_CMO; req_size_i = SZ_PREF;
    req_tid_i = '0; req_need_rsp_i = 1'b1; mem_req_ready_i = 1'b1; filter_clear_i = 1'b0;
    tick(2);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", req_ready_o); end
    checks++; if ({mem_req_valid_o, rsp_valid_o, rsp_error_o, busy_o} !== 4'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {mem_req_valid_o, rsp_valid_o, rsp_error_o, busy_o}); end
    checks++; if ({mem_req_nline_o, rsp_tid_o} !== 32'h0) begin
      errors++; $display("FAIL rst_data got %0h exp 0", {mem_req_nline_o, rsp_tid_o}); end
    rst_ni = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    clear_logs();
    req_valid_i = 1'b1; req_nline_i = 26'h100; req_tid_i = 6'd3;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL t1_ready got %0b exp 1", req_ready_o); end
    tick(1);
    req_valid_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL t1_mem_vld got %0b exp 1", mem_req_valid_o); end
    checks++; if (mem_req_nline_o !== 26'h100) begin errors++; $display("FAIL t1_mem_nline got %0h exp 100", mem_req_nline_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL t1_rsp_early got %0b exp 0", rsp_valid_o); end
    tick(1);
    checks++; if ({rsp_valid_o, rsp_tid_o, rsp_error_o} !== {1'b1, 6'd3, 1'b0}) begin
      errors++; $display("FAIL t1_rsp got v%0b t%0d e%0b exp v1 t3 e0", rsp_valid_o, rsp_tid_o, rsp_error_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL t1_mem_done got %0b exp 0", mem_req_valid_o); end
    tick(1);
    checks++; if ({rsp_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL t1_idle got %b exp 00", {rsp_valid_o, busy_o}); end
  endtask

  task automatic test_illegal();
    clear_logs();
    send(26'h155, 6'd5, OP_LOAD, SZ_PREF, 1'b1);
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL t2_no_fwd got %0b exp 0", mem_req_valid_o); end
    checks++; if ({rsp_valid_o, busy_o} !== 2'b01) begin errors++; $display("FAIL t2_pre got %b exp 01", {rsp_valid_o, busy_o}); end
    tick(1);
    checks++; if ({rsp_valid_o, rsp_tid_o, rsp_error_o} !== {1'b1, 6'd5, 1'b1}) begin
      errors++; $display("FAIL t2_rsp got v%0b t%0d e%0b exp v1 t5 e1", rsp_valid_o, rsp_tid_o, rsp_error_o); end
    tick(1);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL t2_pulse got %0b exp 0", rsp_valid_o); end
    send(26'h156, 6'd6, OP_CMO, 3'h2, 1'b1);
    tick(3);
    checks++; if (fire_q.size() !== 0) begin errors++; $display("FAIL t2_fires got %0d exp 0", fire_q.size()); end
    checks++; if (rtid_q.size() !== 2 || rerr_q[1] !== 1'b1 || rtid_q[1] !== 6'd6) begin
      errors++; $display("FAIL t2_size_err got n%0d exp n2 tid6 err1", rtid_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    req_valid_i = 1'b1; req_nline_i = 26'h200; req_tid_i = 6'd7;
    tick(1);
    req_tid_i = 6'd8;
    checks++; if ({mem_req_valid_o, mem_req_nline_o} !== {1'b1, 26'h200}) begin
      errors++; $display("FAIL t3_first got v%0b n%0h exp v1 n200", mem_req_valid_o, mem_req_nline_o); end
    tick(1);
    req_valid_i = 1'b0;
    tick(4);
    checks++; if (fire_q.size() !== (FLT ? 1 : 2)) begin
      errors++; $display("FAIL t3_fires got %0d exp %0d", fire_q.size(), FLT ? 1 : 2); end
    checks++; if (rtid_q.size() !== 2 || rtid_q[0] !== 6'd7 || rtid_q[1] !== 6'd8 || rerr_q[0] !== 1'b0 || rerr_q[1] !== 1'b0) begin
      errors++; $display("FAIL t3_rsps got n%0d exp tids 7,8 err0", rtid_q.size()); end
  endtask

  task automatic test_full();
    clear_logs();
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; req_nline_i = 26'h400 + 26'(i); req_tid_i = 6'(10 + i);
      tick(1);
      if (i == 2) begin
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL t4_ready3 got %0b exp 1", req_ready_o); end
      end
    end
    req_valid_i = 1'b0;
    checks++; if ({req_ready_o, busy_o, mem_req_valid_o} !== 3'b011) begin
      errors++; $display("FAIL t4_full got %b exp 011", {req_ready_o, busy_o, mem_req_valid_o}); end
    tick(1);
    checks++; if (mem_req_nline_o !== 26'h400) begin errors++; $display("FAIL t4_hold got %0h exp 400", mem_req_nline_o); end
    req_valid_i = 1'b1; req_nline_i = 26'h4FF; req_tid_i = 6'd20; mem_req_ready_i = 1'b1;
    tick(1);
    req_valid_i = 1'b0;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL t4_unfull got %0b exp 1", req_ready_o); end
    tick(6);
    checks++; if (fire_q.size() !== 4) begin errors++; $display("FAIL t4_fires got %0d exp 4", fire_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (fire_q[i] !== 26'h400 + 26'(i)) begin
        errors++; $display("FAIL t4_order%0d got %0h exp %0h", i, fire_q[i], 26'h400 + 26'(i)); end
    end
    checks++; if (rtid_q.size() !== 4 || rtid_q[0] !== 6'd10 || rtid_q[3] !== 6'd13) begin
      errors++; $display("FAIL t4_rsps got n%0d exp 4 tids 10..13", rtid_q.size()); end
  endtask

  task automatic test_filter_wrap();
    clear_logs();
    for (int i = 0; i < 9; i++) send(26'h300 + 26'(i), 6'(i), OP_CMO, SZ_PREF, 1'b1);
    tick(3);
    send(26'h300, 6'd40, OP_CMO, SZ_PREF, 1'b1);
    send(26'h308, 6'd41, OP_CMO, SZ_PREF, 1'b1);
    tick(4);
    checks++; if (fire_q.size() !== (FLT ? 10 : 11)) begin
      errors++; $display("FAIL t5_fires got %0d exp %0d", fire_q.size(), FLT ? 10 : 11); end
    else begin
      checks++; if (fire_q[9] !== 26'h300) begin errors++; $display("FAIL t5_evicted got %0h exp 300", fire_q[9]); end
    end
    checks++; if (rtid_q.size() !== 11 || rtid_q[10] !== 6'd41) begin
      errors++; $display("FAIL t5_rsps got n%0d exp 11", rtid_q.size()); end
  endtask

  task automatic test_filter_clear();
    clear_logs();
    send(26'h700, 6'd1, OP_CMO, SZ_PREF, 1'b1);
    tick(2);
    filter_clear_i = 1'b1; tick(1); filter_clear_i = 1'b0;
    send(26'h700, 6'd2, OP_CMO, SZ_PREF, 1'b1);
    filter_clear_i = 1'b1; tick(1); filter_clear_i = 1'b0;
    tick(2);
    send(26'h700, 6'd3, OP_CMO, SZ_PREF, 1'b1);
    tick(2);
    send(26'h700, 6'd4, OP_CMO, SZ_PREF, 1'b1);
    tick(3);
    checks++; if (fire_q.size() !== (FLT ? 3 : 4)) begin
      errors++; $display("FAIL t_clear_fires got %0d exp %0d", fire_q.size(), FLT ? 3 : 4); end
    checks++; if (rtid_q.size() !== 4) begin errors++; $display("FAIL t_clear_rsps got %0d exp 4", rtid_q.size()); end
  endtask

  task automatic test_need_rsp_and_reset();
    clear_logs();
    send(26'h500, 6'd9, OP_CMO, SZ_PREF, 1'b0);
    tick(3);
    checks++; if (fire_q.size() !== 1 || fire_q[0] !== 26'h500) begin
      errors++; $display("FAIL t6_fwd got n%0d exp 1 at 500", fire_q.size()); end
    checks++; if (rtid_q.size() !== 0) begin errors++; $display("FAIL t6_no_rsp got %0d exp 0", rtid_q.size()); end
    clear_logs();
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(26'h600 + 26'(i), 6'(20 + i), OP_CMO, SZ_PREF, 1'b1);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t6_busy got %0b exp 1", busy_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if ({req_ready_o, mem_req_valid_o, rsp_valid_o, rsp_error_o, busy_o} !== 5'b10000) begin
      errors++; $display("FAIL t6_rst_flags got %b exp 10000", {req_ready_o, mem_req_valid_o, rsp_valid_o, rsp_error_o, busy_o}); end
    checks++; if ({mem_req_nline_o, rsp_tid_o} !== 32'h0) begin
      errors++; $display("FAIL t6_rst_data got %0h exp 0", {mem_req_nline_o, rsp_tid_o}); end
    tick(1);
    rst_ni = 1'b1; mem_req_ready_i = 1'b1;
    tick(4);
    checks++; if (fire_q.size() !== 0 || rtid_q.size() !== 0) begin
      errors++; $display("FAIL t6_discard got f%0d r%0d exp 0 0", fire_q.size(), rtid_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_back_to_back();
    test_full();
    test_filter_wrap();
    test_filter_clear();
    test_need_rsp_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
